// File: rtl/x2050_stat.sv
// 2050 STAT register S0..S7 with decimal carry (S1) and sticky nonzero (S2) latches.
// S1 is loaded from the byte-selected carry on DCBS; adder reads it back one iteration later.
module x2050_stat (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_adv,
    input  logic [3:0] i_ss,
    input  logic [3:0] i_e,
    input  logic       i_ad_dcbs,
    input  logic       i_cx_bs,
    input  logic       i_z_nz,
    input  logic       i_ci_stat,
    output logic [7:0] o_stat,
    output logic       o_carry_in,
    output logic       o_dec_nz,
    output logic       o_dec_cy_chg
);

    typedef enum logic [3:0] {
        SS_NOP     = 4'd0,
        SS_EMIT    = 4'd1,
        SS_SET_S0  = 4'd2,
        SS_CLR_S1  = 4'd3,
        SS_ACC_NZ  = 4'd4,
        SS_DEC_BEG = 4'd5,
        SS_SET_S4  = 4'd6,
        SS_CLR_S4  = 4'd7,
        SS_CLR_ALL = 4'd8
    } ss_e;

    // Bit 7 is S0, bit 0 is S7.
    localparam int unsigned S0 = 7;
    localparam int unsigned S1 = 6;
    localparam int unsigned S2 = 5;
    localparam int unsigned S4 = 3;

    logic [7:0] r_stat;
    logic       r_cy_chg;
    logic [7:0] w_next;

    always_comb begin
        w_next = r_stat;
        case (i_ss)
            SS_EMIT:    w_next[7:4] = i_e;
            SS_SET_S0:  w_next[S0]  = 1'b1;
            SS_CLR_S1:  w_next[S1]  = 1'b0;
            SS_ACC_NZ:  w_next[S2]  = r_stat[S2] | i_z_nz;
            SS_DEC_BEG: begin
                w_next[S2] = 1'b0;
                w_next[S1] = 1'b0;
            end
            SS_SET_S4:  w_next[S4]  = 1'b1;
            SS_CLR_S4:  w_next[S4]  = 1'b0;
            SS_CLR_ALL: w_next      = '0;
            default:    w_next      = r_stat;
        endcase
        // DCBS carry latch wins over any SS effect on S1.
        if (i_ad_dcbs) begin
            w_next[S1] = i_cx_bs;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_stat   <= '0;
            r_cy_chg <= 1'b0;
        end else if (i_adv) begin
            r_stat   <= w_next;
            r_cy_chg <= w_next[S1] ^ r_stat[S1];
        end else begin
            r_cy_chg <= 1'b0;
        end
    end

    assign o_stat       = r_stat;
    assign o_carry_in   = i_ci_stat & r_stat[S1];
    assign o_dec_nz     = r_stat[S2];
    assign o_dec_cy_chg = r_cy_chg;

endmodule
